sqrt_share_ctrl: RTL and testbench
==================================

Name: sqrt_share_ctrl

Overview:
- Shares one iterative square-root unit (`sqrt`, 8/24 single precision) between NUM_REQ requesters.
- Round-robin arbitration; one operation in flight at a time.
- Latches the winner's operand and rounding mode, then sequences the unit's in_valid/in_ready handshake.
- Holds the result in a one-entry response buffer until the owning requester takes it. Handles per-requester cancel and a latency watchdog.
- Sits between the FPU issue ports and the shared `sqrt` instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- EXP_W, 8, exponent width passed to the sqrt unit.
- MANT_W, 24, mantissa width incl. hidden bit; operand width W = EXP_W+MANT_W.
- TIMEOUT, 31, maximum cycles in BUSY before the watchdog aborts.

Ports:
- clk  in  1  clock
- rst_l  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot accept
- req_a  in  NUM_REQ*W  packed operands, requester i at [i*W +: W]
- req_rm  in  NUM_REQ*3  packed rounding modes
- req_cancel  in  NUM_REQ  flush of requester's outstanding op
- resp_valid  out  NUM_REQ  one-hot result valid
- resp_ready  in  NUM_REQ  per-requester result accept
- resp_out  out  W  result (shared bus)
- resp_exc  out  5  exception flags {NV,DZ,OF,UF,NX}
- resp_tmo  out  1  result produced by watchdog abort
- sq_in_valid  out  1  to sqrt in_valid
- sq_a  out  W  to sqrt a
- sq_round_mode  out  3  to sqrt round_mode
- sq_cancel  out  1  to sqrt cancel
- sq_in_ready  in  1  from sqrt in_ready
- sq_out_valid  in  1  from sqrt out_valid
- sq_out  in  W  from sqrt out
- sq_exceptions  in  5  from sqrt exceptions

Behaviour:
- Single clock. Asynchronous active-low reset: rst_l low → state IDLE, rr pointer = NUM_REQ-1, all registers 0.
  - Reset values: req_ready, resp_valid, sq_in_valid, sq_cancel, resp_tmo = 0; resp_out, resp_exc, sq_a, sq_round_mode = 0.
- FSM states IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - Grant = first i with req_valid[i] & !req_cancel[i], searching from pointer+1 with wrap-around.
  - req_ready[grant] = 1 combinationally.
  - On grant: latch owner id, operand and rm; pointer ← owner; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - sq_in_valid = 1 and sq_a = latched operand.
  - On sq_in_ready: go to BUSY, clear the watchdog counter.
  - Minimum latency from accept: T accept, T+1 issue, T+2 BUSY.
- sq_round_mode: driven from the latched rm from ISSUE through the sq_out_valid cycle (the unit rounds with its live round_mode input at output time).
- BUSY:
  - Watchdog counter increments each cycle.
  - On sq_out_valid: capture sq_out/sq_exceptions into the response buffer, resp_tmo = 0, go to RESP.
  - Special-case operands return in 1 cycle; normal operands take ~MANT_W+1 cycles.
- Watchdog: counter reaches TIMEOUT in BUSY with no out_valid →
  - sq_cancel pulses 1 cycle;
  - buffer ← canonical qNaN (0x7FC00000 for 8/24), exc = 5'b10000, resp_tmo = 1;
  - go to RESP.
- RESP:
  - resp_valid[owner] = 1, stable until resp_ready[owner].
  - On accept: go to IDLE. A new grant is possible the following cycle; no back-to-back grant in the accept cycle.
- Cancel:
  - req_cancel[owner] in ISSUE or BUSY → sq_cancel pulses 1 cycle, go to IDLE, no response.
  - req_cancel[owner] in RESP → drop buffer, go to IDLE.
  - Cancel from a non-owner is ignored.
- Simultaneous events:
  - sq_out_valid and owner cancel in the same cycle: cancel wins, result discarded.
  - Watchdog expiry and out_valid in the same cycle: out_valid wins.
  - A requester with req_cancel high is skipped by the arbiter in that cycle.
- Fairness: after owner i is served, every other requester holding valid is granted before i again.
- Reset mid-operation: FSM returns to IDLE asynchronously. The sqrt unit shares rst_l, so it is also cleared; no sq_cancel is needed.

Decomposition:
- Package sqrt_share_pkg: state enum {IDLE, ISSUE, BUSY, RESP}; canonical-NaN and NV-flag localparams; owner-id width = clog2(NUM_REQ).
- Sub-module rr_arbiter: NUM_REQ-wide round-robin, inputs req/mask/pointer, outputs one-hot grant and encoded id.
- The FSM, buffer and watchdog stay in sqrt_share_ctrl.

Test Plan:
- Req0 a=0x40800000 (4.0), rm=0 → sq_in_valid at T+1; resp_valid[0] with resp_out=0x40000000, resp_exc=0, resp_tmo=0.
- Req2 a=0xBF800000 (-1.0) → 1-cycle unit latency; resp_out=0x7FC00000, resp_exc=5'b10000.
- All four req_valid held, every op 0x41100000 (9.0) → grants in order 0,1,2,3,0; each resp_out=0x40400000; no requester starved.
- Req1 a=0x40000000; req_cancel[1] asserted 5 cycles into BUSY → one-cycle sq_cancel, no resp_valid, next grant goes to a waiting req3.
- Unit model stalls out_valid past TIMEOUT → sq_cancel pulse; resp_out=0x7FC00000, resp_exc=5'b10000, resp_tmo=1.
- rst_l low during BUSY, then released → all outputs 0, state IDLE; a fresh 4.0 request completes correctly.

Source files
------------

// File: rtl/sqrt_share_pkg.sv
// Shared types and constants for the square-root sharing controller.
// State encoding, exception flag constants and width helpers.
package sqrt_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP
  } state_e;

  localparam logic [4:0] EXC_NV = 5'b10000;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, top fraction bit set.
  function automatic logic [63:0] canon_nan(input int exp_w, input int mant_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[mant_w - 1 + i] = 1'b1;
    r[mant_w - 2] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/sqrt_share_ctrl_if.sv
// Link between the sharing controller (master) and the sqrt unit (slave).
// Valid/ready issue side, single-cycle out_valid result side, cancel strobe.
interface sqrt_share_ctrl_if #(
  parameter int W = 32
);
  logic         sq_in_valid;
  logic [W-1:0] sq_a;
  logic [2:0]   sq_round_mode;
  logic         sq_cancel;
  logic         sq_in_ready;
  logic         sq_out_valid;
  logic [W-1:0] sq_out;
  logic [4:0]   sq_exceptions;

  modport master (
    output sq_in_valid, sq_a, sq_round_mode, sq_cancel,
    input  sq_in_ready, sq_out_valid, sq_out, sq_exceptions
  );

  modport slave (
    input  sq_in_valid, sq_a, sq_round_mode, sq_cancel,
    output sq_in_ready, sq_out_valid, sq_out, sq_exceptions
  );
endinterface

// File: rtl/sqrt_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational, zero latency; searches from ptr+1 with wrap.
// No backpressure of its own; masked requesters are skipped for the cycle.
module rr_arbiter
  import sqrt_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx] && mask[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Shares one iterative sqrt unit among NUM_REQ requesters; accept T, issue T+1, BUSY T+2.
// One op in flight; the result is held in a one-entry buffer until its owner takes it.
module sqrt_share_ctrl
  import sqrt_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int EXP_W   = 8,
  parameter int MANT_W  = 24,
  parameter int TIMEOUT = 31,
  localparam int W = EXP_W + MANT_W
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*3-1:0] req_rm,
  input  logic [NUM_REQ-1:0]   req_cancel,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [W-1:0]         resp_out,
  output logic [4:0]           resp_exc,
  output logic                 resp_tmo,
  sqrt_share_ctrl_if.master    sq
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] QNAN = W'(canon_nan(EXP_W, MANT_W));

  state_e               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [W-1:0]         sq_a_q, sq_a_d;
  logic [2:0]           sq_rm_q, sq_rm_d;
  logic                 sq_in_valid_q, sq_in_valid_d;
  logic                 sq_cancel_q, sq_cancel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [W-1:0]         resp_out_q, resp_out_d;
  logic [4:0]           resp_exc_q, resp_exc_d;
  logic                 resp_tmo_q, resp_tmo_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [NUM_REQ-1:0]   arb_mask;
  logic [ID_W-1:0]      arb_id;
  logic [NUM_REQ-1:0]   owner_oh;
  logic                 owner_cancel;
  logic                 owner_accept;

  assign arb_mask = ~req_cancel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req_valid),
    .mask   (arb_mask),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  assign owner_oh     = NUM_REQ'(1) << owner_q;
  assign owner_cancel = req_cancel[owner_q];
  assign owner_accept = resp_ready[owner_q];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    sq_a_d        = sq_a_q;
    sq_rm_d       = sq_rm_q;
    sq_in_valid_d = sq_in_valid_q;
    sq_cancel_d   = 1'b0;
    cnt_d         = cnt_q;
    resp_valid_d  = resp_valid_q;
    resp_out_d    = resp_out_q;
    resp_exc_d    = resp_exc_q;
    resp_tmo_d    = resp_tmo_q;
    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          owner_d       = arb_id;
          ptr_d         = arb_id;
          sq_a_d        = req_a[int'(arb_id)*W +: W];
          sq_rm_d       = req_rm[int'(arb_id)*3 +: 3];
          sq_in_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_cancel) begin
          sq_in_valid_d = 1'b0;
          sq_rm_d       = '0;
          sq_cancel_d   = 1'b1;
          state_d       = IDLE;
        end else if (sq.sq_in_ready) begin
          sq_in_valid_d = 1'b0;
          cnt_d         = '0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        // Priority: owner cancel, then a real result, then the watchdog.
        if (owner_cancel) begin
          sq_rm_d     = '0;
          sq_cancel_d = 1'b1;
          state_d     = IDLE;
        end else if (sq.sq_out_valid) begin
          sq_rm_d      = '0;
          resp_out_d   = sq.sq_out;
          resp_exc_d   = sq.sq_exceptions;
          resp_tmo_d   = 1'b0;
          resp_valid_d = owner_oh;
          state_d      = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          sq_rm_d      = '0;
          sq_cancel_d  = 1'b1;
          resp_out_d   = QNAN;
          resp_exc_d   = EXC_NV;
          resp_tmo_d   = 1'b1;
          resp_valid_d = owner_oh;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (owner_cancel || owner_accept) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= IDLE;
      ptr_q         <= ID_W'(NUM_REQ - 1);
      owner_q       <= '0;
      sq_a_q        <= '0;
      sq_rm_q       <= '0;
      sq_in_valid_q <= 1'b0;
      sq_cancel_q   <= 1'b0;
      cnt_q         <= '0;
      resp_valid_q  <= '0;
      resp_out_q    <= '0;
      resp_exc_q    <= '0;
      resp_tmo_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      sq_a_q        <= sq_a_d;
      sq_rm_q       <= sq_rm_d;
      sq_in_valid_q <= sq_in_valid_d;
      sq_cancel_q   <= sq_cancel_d;
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_out_q    <= resp_out_d;
      resp_exc_q    <= resp_exc_d;
      resp_tmo_q    <= resp_tmo_d;
    end
  end

  assign req_ready        = (state_q == IDLE) ? arb_gnt : '0;
  assign resp_valid       = resp_valid_q;
  assign resp_out         = resp_out_q;
  assign resp_exc         = resp_exc_q;
  assign resp_tmo         = resp_tmo_q;
  assign sq.sq_in_valid   = sq_in_valid_q;
  assign sq.sq_a          = sq_a_q;
  assign sq.sq_round_mode = sq_rm_q;
  assign sq.sq_cancel     = sq_cancel_q;

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Directed bench for sqrt_share_ctrl with a behavioural sqrt unit on the slave side.
module tb_sqrt_share_ctrl;

  localparam int NR = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a;
  logic [NR*3-1:0] req_rm;
  logic [NR-1:0]   req_cancel;
  logic [NR-1:0]   resp_valid;
  logic [NR-1:0]   resp_ready;
  logic [W-1:0]    resp_out;
  logic [4:0]      resp_exc;
  logic            resp_tmo;

  sqrt_share_ctrl_if #(.W(W)) sq_if ();

  sqrt_share_ctrl dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_rm     (req_rm),
    .req_cancel (req_cancel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_exc   (resp_exc),
    .resp_tmo   (resp_tmo),
    .sq         (sq_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Behavioural sqrt unit: special operands answer in 1 cycle, others in 25.
  logic        m_busy, m_stall;
  int          m_cnt;
  logic [31:0] m_res;
  logic [4:0]  m_exc;
  logic        s_iv, s_ir, s_cn;
  logic [31:0] s_a;

  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    case (a)
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h4000_0000: return 32'h3FB5_04F3;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  initial begin
    sq_if.sq_in_ready   = 1'b0;
    sq_if.sq_out_valid  = 1'b0;
    sq_if.sq_out        = '0;
    sq_if.sq_exceptions = '0;
    m_busy  = 1'b0;
    m_stall = 1'b0;
    m_cnt   = 0;
    m_res   = '0;
    m_exc   = '0;
    forever begin
      @(negedge clk);
      s_iv = sq_if.sq_in_valid;
      s_ir = sq_if.sq_in_ready;
      s_a  = sq_if.sq_a;
      s_cn = sq_if.sq_cancel;
      @(posedge clk);
      #1;
      sq_if.sq_out_valid = 1'b0;
      if (!rst_l || s_cn) begin
        m_busy = 1'b0;
      end else begin
        if (s_iv && s_ir) begin
          m_busy = 1'b1;
          if (s_a[31] && s_a[30:0] != 0) begin
            m_res = 32'h7FC0_0000;
            m_exc = 5'b10000;
            m_cnt = 1;
          end else begin
            m_res = ref_sqrt(s_a);
            m_exc = 5'b00000;
            m_cnt = 25;
          end
        end
        if (m_busy && !m_stall) begin
          m_cnt--;
          if (m_cnt == 0) begin
            sq_if.sq_out_valid  = 1'b1;
            sq_if.sq_out        = m_res;
            sq_if.sq_exceptions = m_exc;
            m_busy = 1'b0;
          end
        end
      end
      sq_if.sq_in_ready = rst_l && !m_busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int budget, output int waited, output logic ok);
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < budget) begin
      @(negedge clk);
      waited++;
      if (resp_valid != '0) ok = 1'b1;
    end
  endtask

  task automatic run_one(input int id, input logic [31:0] a, input logic [2:0] rm,
                         input logic [31:0] e_out, input logic [4:0] e_exc,
                         input int e_wait, input string tag);
    int w;
    logic ok;
    logic [NR-1:0] oh;
    oh = NR'(1) << id;
    req_a[id*W +: W] = a;
    req_rm[id*3 +: 3] = rm;
    req_valid = oh;
    @(negedge clk);
    chk({tag, ".ready"}, 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    @(negedge clk);
    chk({tag, ".in_valid"}, 32'(sq_if.sq_in_valid), 32'd1);
    chk({tag, ".sq_a"}, sq_if.sq_a, a);
    chk({tag, ".rm"}, 32'(sq_if.sq_round_mode), 32'(rm));
    wait_resp(60, w, ok);
    chk({tag, ".resp_seen"}, 32'(ok), 32'd1);
    if (e_wait != 0) chk({tag, ".latency"}, 32'(w), 32'(e_wait));
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(oh));
    chk({tag, ".out"}, resp_out, e_out);
    chk({tag, ".exc"}, 32'(resp_exc), 32'(e_exc));
    chk({tag, ".tmo"}, 32'(resp_tmo), 32'd0);
    step();
    @(negedge clk);
    chk({tag, ".hold"}, 32'(resp_valid), 32'(oh));
    resp_ready = oh;
    step();
    resp_ready = '0;
    @(negedge clk);
    chk({tag, ".drop"}, 32'(resp_valid), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int w;
    logic ok;
    logic seen;
    logic [NR-1:0] oh;

    rst_l      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_rm     = '0;
    req_cancel = '0;
    resp_ready = '0;
    repeat (3) @(negedge clk);

    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.sq_in_valid", 32'(sq_if.sq_in_valid), 32'd0);
    chk("rst.sq_cancel", 32'(sq_if.sq_cancel), 32'd0);
    chk("rst.resp_tmo", 32'(resp_tmo), 32'd0);
    chk("rst.resp_out", resp_out, 32'd0);
    chk("rst.resp_exc", 32'(resp_exc), 32'd0);
    chk("rst.sq_a", sq_if.sq_a, 32'd0);
    chk("rst.sq_rm", 32'(sq_if.sq_round_mode), 32'd0);

    rst_l = 1'b1;
    step();
    step();

    run_one(0, 32'h4080_0000, 3'd0, 32'h4000_0000, 5'b00000, 26, "sqrt4");
    run_one(2, 32'hBF80_0000, 3'd2, 32'h7FC0_0000, 5'b10000, 2, "neg1");

    // Fresh pointer so the rotation starts at requester 0.
    @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    step();
    for (int i = 0; i < NR; i++) req_a[i*W +: W] = 32'h4110_0000;
    resp_ready = '1;
    req_valid  = '1;
    for (int g = 0; g < 5; g++) begin
      oh = NR'(1) << (g % NR);
      @(negedge clk);
      w = 0;
      while (req_ready == '0 && w < 60) begin
        @(negedge clk);
        w++;
      end
      chk($sformatf("rr%0d.grant", g), 32'(req_ready), 32'(oh));
      step();
      wait_resp(60, w, ok);
      chk($sformatf("rr%0d.seen", g), 32'(ok), 32'd1);
      chk($sformatf("rr%0d.resp_valid", g), 32'(resp_valid), 32'(oh));
      chk($sformatf("rr%0d.out", g), resp_out, 32'h4040_0000);
      step();
    end
    req_valid  = '0;
    resp_ready = '0;
    step();

    // Owner cancel during BUSY, with requester 3 waiting.
    req_a[1*W +: W] = 32'h4000_0000;
    req_a[3*W +: W] = 32'h4110_0000;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("cx.grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("cx.ready_issue", 32'(req_ready), 32'd0);
    step();
    repeat (5) step();
    req_cancel = 4'b0010;
    @(negedge clk);
    chk("cx.no_early_pulse", 32'(sq_if.sq_cancel), 32'd0);
    step();
    req_cancel = '0;
    @(negedge clk);
    chk("cx.pulse", 32'(sq_if.sq_cancel), 32'd1);
    chk("cx.no_resp", 32'(resp_valid), 32'd0);
    chk("cx.next_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("cx.pulse_end", 32'(sq_if.sq_cancel), 32'd0);
    chk("cx.issue3", 32'(sq_if.sq_in_valid), 32'd1);
    wait_resp(60, w, ok);
    chk("cx.seen3", 32'(ok), 32'd1);
    chk("cx.resp_valid3", 32'(resp_valid), 32'b1000);
    chk("cx.out3", resp_out, 32'h4040_0000);
    resp_ready = 4'b1000;
    step();
    resp_ready = '0;
    step();

    // Watchdog abort with a stalled unit.
    m_stall = 1'b1;
    req_a[0 +: W] = 32'h4080_0000;
    req_valid = 4'b0001;
    @(negedge clk);
    step();
    req_valid = '0;
    w = 0;
    seen = 1'b0;
    while (!seen && w < 80) begin
      @(negedge clk);
      w++;
      if (sq_if.sq_cancel) seen = 1'b1;
    end
    chk("to.cancel_seen", 32'(seen), 32'd1);
    chk("to.window", 32'(w >= 32 && w <= 36), 32'd1);
    chk("to.resp_valid", 32'(resp_valid), 32'b0001);
    chk("to.out", resp_out, 32'h7FC0_0000);
    chk("to.exc", 32'(resp_exc), 32'b10000);
    chk("to.tmo", 32'(resp_tmo), 32'd1);
    step();
    @(negedge clk);
    chk("to.pulse_1cyc", 32'(sq_if.sq_cancel), 32'd0);
    chk("to.hold", 32'(resp_valid), 32'b0001);
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    m_stall = 1'b0;
    step();

    // Reset while BUSY, then a fresh request.
    req_a[0 +: W] = 32'h4080_0000;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (6) step();
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("mid.sq_in_valid", 32'(sq_if.sq_in_valid), 32'd0);
    chk("mid.resp_valid", 32'(resp_valid), 32'd0);
    chk("mid.resp_out", resp_out, 32'd0);
    chk("mid.resp_exc", 32'(resp_exc), 32'd0);
    chk("mid.resp_tmo", 32'(resp_tmo), 32'd0);
    chk("mid.sq_cancel", 32'(sq_if.sq_cancel), 32'd0);
    chk("mid.sq_a", sq_if.sq_a, 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    step();
    run_one(0, 32'h4080_0000, 3'd0, 32'h4000_0000, 5'b00000, 26, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
